// File: rtl/animation_sequencer.sv
// -----------------------------------------------------------------------------
// animation_sequencer
//
// Purpose:
//   Steps through the frames of the current animation at a programmable frame
//   rate and moves between animations. The current animation index addresses
//   an external frame-limit table that returns the last frame index of that
//   animation. The (animation, frame) pair addresses the segment-pattern ROM.
//
//   A prescaler divides clk into frame ticks: one tick every tick_period+1
//   cycles. On a tick the frame counter advances. When the frame limit has been
//   reached, the frame counter returns to 0 and ani_done pulses. If auto_adv is
//   set, the animation index also advances, wrapping from NUM_ANI-1 to 0.
//   A load pulse jumps to ani_sel, and a next pulse skips to the following
//   animation. Both restart the frame and the prescaler.
//   Priority on each edge is rst > load > next > tick.
//
// Ports:
//   clk          in   1      system clock
//   rst          in   1      synchronous reset, active-high
//   ena          in   1      1 = prescaler/frame counting runs, 0 = frozen
//   tick_period  in   DIV_W  a frame lasts tick_period+1 clk cycles
//   auto_adv     in   1      1 = advance animation after its last frame
//   next         in   1      pulse: skip to the next animation
//   load         in   1      pulse: jump to ani_sel (out of range -> 0)
//   ani_sel      in   6      target animation for load
//   limit        in   6      last frame index of the current animation
//   animation    out  6      current animation index
//   frame        out  6      current frame index, 0..limit
//   frame_stb    out  1      pulse: animation and/or frame changed on last edge
//   ani_done     out  1      pulse: last frame of an animation completed
// -----------------------------------------------------------------------------
module animation_sequencer #(
    parameter int DIV_W   = 24,
    parameter int NUM_ANI = 51
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic [DIV_W-1:0] tick_period,
    input  logic             auto_adv,
    input  logic             next,
    input  logic             load,
    input  logic [5:0]       ani_sel,
    input  logic [5:0]       limit,
    output logic [5:0]       animation,
    output logic [5:0]       frame,
    output logic             frame_stb,
    output logic             ani_done
);

    localparam logic [5:0] LAST_ANI    = 6'(NUM_ANI - 1);
    // One bit wider than ani_sel so that NUM_ANI = 64 is representable.
    localparam logic [6:0] NUM_ANI_EXT = 7'(NUM_ANI);

    logic [DIV_W-1:0] prescaler_q, prescaler_d;
    logic [5:0]       animation_q, animation_d;
    logic [5:0]       frame_q,     frame_d;
    logic             frame_stb_q, frame_stb_d;
    logic             ani_done_q,  ani_done_d;

    logic             tick;
    logic [5:0]       ani_succ;

    // A '>=' compare: lowering tick_period below the current count ticks on
    // the next cycle instead of running the prescaler through its full range.
    assign tick     = ena && (prescaler_q >= tick_period);
    assign ani_succ = (animation_q == LAST_ANI) ? 6'd0 : animation_q + 6'd1;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned; otherwise synthesis infers a latch to hold the old value.
        prescaler_d = prescaler_q;
        animation_d = animation_q;
        frame_d     = frame_q;
        frame_stb_d = 1'b0;
        ani_done_d  = 1'b0;

        if (load) begin
            animation_d = ({1'b0, ani_sel} >= NUM_ANI_EXT) ? 6'd0 : ani_sel;
            frame_d     = 6'd0;
            prescaler_d = '0;
            frame_stb_d = 1'b1;
        end else if (next) begin
            // A skip is not a completed animation, so ani_done stays low.
            animation_d = ani_succ;
            frame_d     = 6'd0;
            prescaler_d = '0;
            frame_stb_d = 1'b1;
        end else if (tick) begin
            prescaler_d = '0;
            frame_stb_d = 1'b1;
            if (frame_q < limit) begin
                frame_d = frame_q + 6'd1;
            end else begin
                // '>=' also covers a limit that shrank below the current frame.
                frame_d    = 6'd0;
                ani_done_d = 1'b1;
                if (auto_adv) begin
                    animation_d = ani_succ;
                end
            end
        end else if (ena) begin
            prescaler_d = prescaler_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            prescaler_q <= '0;
            animation_q <= 6'd0;
            frame_q     <= 6'd0;
            frame_stb_q <= 1'b0;
            ani_done_q  <= 1'b0;
        end else begin
            prescaler_q <= prescaler_d;
            animation_q <= animation_d;
            frame_q     <= frame_d;
            frame_stb_q <= frame_stb_d;
            ani_done_q  <= ani_done_d;
        end
    end

    assign animation = animation_q;
    assign frame     = frame_q;
    assign frame_stb = frame_stb_q;
    assign ani_done  = ani_done_q;

endmodule
